// File: rtl/dct_zigzag_quant_if.sv
// Handshake bundle for dct_zigzag_quant: raster coefficient input stream and
// zigzag-ordered quantized output stream.
interface dct_zigzag_quant_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [5:0]    out_idx;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dct_zigzag_quant.sv
// Ping-pong 8x8 block buffer: accepts raster coefficients, re-emits them in JPEG
// zigzag order right-shifted by QSHIFT. Define DCT_QTABLE_EN for per-band extra shift.
module dct_zigzag_quant #(
  parameter int          DW     = 8,
  parameter int unsigned QSHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  dct_zigzag_quant_if.slave   bus
);

  localparam int unsigned ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [5:0]    wr_cnt_q, wr_cnt_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q,   full_d;
  logic [DW-1:0] mem_q [128];

  logic          in_ready;
  logic          out_valid;
  logic          in_xfer;
  logic          out_xfer;
  logic [5:0]    zz_addr;
  logic [DW-1:0] raw;
  int unsigned   sh;

  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;
    // Write and read never address the same bank, so both updates can land together.
    if (in_xfer) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
    if (out_xfer) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) mem_q[{wr_sel_q, wr_cnt_q}] <= bus.in_data;
  end

  always_comb begin
    zz_addr = 6'(ZZ[rd_cnt_q]);
    raw     = mem_q[{rd_sel_q, zz_addr}];
`ifdef DCT_QTABLE_EN
    sh = QSHIFT + 32'(rd_cnt_q[5:4]);
`else
    sh = QSHIFT;
`endif
    bus.out_data = (sh >= 32'(DW)) ? '0 : (raw >> sh);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = rd_cnt_q;
  assign bus.out_last  = (rd_cnt_q == 6'd63);

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// Bench for dct_zigzag_quant: two instances (QSHIFT 0 and 2) share one stimulus;
// a zigzag scoreboard plus table vectors and hand-written handshake corner cases.
module tb_dct_zigzag_quant;
  localparam int DW = 8;
`ifdef DCT_QTABLE_EN
  localparam bit QT = 1'b1;
`else
  localparam bit QT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  always #5 clk = ~clk;

  dct_zigzag_quant_if #(.DW(DW)) bus0 ();
  dct_zigzag_quant_if #(.DW(DW)) bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_data   = in_data;
  assign bus2.out_ready = out_ready;

  dct_zigzag_quant #(.DW(DW), .QSHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dct_zigzag_quant #(.DW(DW), .QSHIFT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [1:0] irdy, oval, olast;
  logic [7:0] odata [2];
  logic [5:0] oidx  [2];
  assign irdy[0] = bus0.in_ready;  assign irdy[1] = bus2.in_ready;
  assign oval[0] = bus0.out_valid; assign oval[1] = bus2.out_valid;
  assign olast[0] = bus0.out_last; assign olast[1] = bus2.out_last;
  assign odata[0] = bus0.out_data; assign odata[1] = bus2.out_data;
  assign oidx[0] = bus0.out_idx;   assign oidx[1] = bus2.out_idx;

  typedef struct { logic [7:0] data; logic [5:0] idx; logic last; } exp_t;
  typedef struct { logic [7:0] v; logic [7:0] e0; logic [7:0] e2; } vec_t;

  exp_t sbq0 [$];
  exp_t sbq1 [$];
  int   zz [64];
  int   qs [2] = '{0, 2};
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] qexp(input logic [7:0] v, input int q, input int idx);
    int s;
    s = q;
    if (QT) s = s + idx / 16;
    return (s >= 8) ? 8'h00 : (v >> s);
  endfunction

  // Scoreboard: buffers accepted raster samples; each completed block pushes 64 zigzag expectations.
  task automatic monitor();
    logic [7:0] blk [2][64];
    int         wcnt [2];
    logic       stall [2];
    logic [7:0] sd [2];
    logic [5:0] si [2];
    logic       sl [2];
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          chk("rst_oval", oval[d] == 1'b0, 32'(oval[d]), 0);
          wcnt[d] = 0;
          stall[d] = 1'b0;
        end
        sbq0.delete();
        sbq1.delete();
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (in_valid && irdy[d]) begin
            blk[d][wcnt[d]] = in_data;
            wcnt[d]++;
            if (wcnt[d] == 64) begin
              for (int k = 0; k < 64; k++) begin
                e.data = qexp(blk[d][zz[k]], qs[d], k);
                e.idx  = 6'(k);
                e.last = (k == 63);
                if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
              end
              wcnt[d] = 0;
            end
          end
          if (stall[d])
            chk("hold", oval[d] && odata[d] == sd[d] && oidx[d] == si[d] && olast[d] == sl[d],
                {oval[d], olast[d], oidx[d], odata[d]}, {1'b1, sl[d], si[d], sd[d]});
          if (oval[d] && out_ready) begin
            if ((d == 0 ? sbq0.size() : sbq1.size()) == 0) begin
              chk("spurious_out", 1'b0, {olast[d], oidx[d], odata[d]}, 0);
            end else begin
              e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
              chk(d == 0 ? "out_q0" : "out_q2",
                  odata[d] == e.data && oidx[d] == e.idx && olast[d] == e.last,
                  {olast[d], oidx[d], odata[d]}, {e.last, e.idx, e.data});
            end
          end
          stall[d] = oval[d] && !out_ready;
          sd[d] = odata[d];
          si[d] = oidx[d];
          sl[d] = olast[d];
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", irdy == 2'b11 && oval == 2'b00 && olast == 2'b00 && oidx[0] == 0 && oidx[1] == 0,
        {irdy, oval, olast}, 6'b110000);
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Holds v on the input until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = v;
    while (!irdy[0] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("send_timeout", 1'b0, n, 400);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sbq0.size() != 0 || sbq1.size() != 0 || oval != 2'b00) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", n < 500, n, 500);
  endtask

  initial begin
    vec_t tab [7];
    int   idx, n, cyc, acc, nout, nlast;
    bit   early, gap, dropped, started;

    #200000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tab [7];
    int   idx, n, cyc, acc, nout, nlast;
    bit   early, gap, dropped, started;

    tab[0] = '{8'hFF, 8'hFF, 8'h3F};
    tab[1] = '{8'h00, 8'h00, 8'h00};
    tab[2] = '{8'h80, 8'h80, 8'h20};
    tab[3] = '{8'h03, 8'h03, 8'h00};
    tab[4] = '{8'h7F, 8'h7F, 8'h1F};
    tab[5] = '{8'h10, 8'h10, 8'h04};
    tab[6] = '{8'h05, 8'h05, 8'h01};

    // Zigzag order derived from anti-diagonal walks, independent of the RTL table.
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[idx] = r * 8 + (s - r); idx++; end
      else            for (int r = lo; r <= hi; r++) begin zz[idx] = r * 8 + (s - r); idx++; end
    end

    fork
      monitor();
    join_none

    // Ramp 0..63, latency of first out_valid.
    do_reset();
    out_ready = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send(8'(i));
      if (i < 63 && oval != 2'b00) early = 1'b1;
    end
    in_valid = 1'b0;
    chk("first_valid_latency", oval == 2'b11 && !early, {early, oval}, 3'b011);
    chk("first_idx", oidx[0] == 0 && oidx[1] == 0, {oidx[0], oidx[1]}, 0);
    drain();

    // Constant-block table vectors.
    for (int r = 0; r < 7; r++) begin
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) send(tab[r].v);
      in_valid = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 64 && cyc < 200) begin
        @(negedge clk);
        if (oval[0]) begin
          if (oidx[0] < 16 || !QT) chk("tab_q0", odata[0] == tab[r].e0, odata[0], tab[r].e0);
          if (oidx[1] < 16 || !QT) chk("tab_q2", odata[1] == tab[r].e2, odata[1], tab[r].e2);
          n++;
        end
        cyc++;
      end
      chk("tab_count", n == 64, n, 64);
      @(posedge clk); #1;
    end

    // Both banks full, 129th input stalls, in_ready returns after one block drains.
    do_reset();
    for (int i = 0; i < 128; i++) send(8'(i));
    chk("both_full_ready", irdy == 2'b00, irdy, 0);
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_129", irdy == 2'b00 && oval == 2'b11, {irdy, oval}, 4'b0011);
    out_ready = 1'b1;
    n = 0;
    cyc = 0;
    early = 1'b0;
    while (n < 64 && cyc < 300) begin
      @(negedge clk);
      if (oval[0]) n++;
      @(posedge clk); #1;
      if (n < 64 && irdy != 2'b00) early = 1'b1;
      cyc++;
    end
    chk("ready_rise", irdy == 2'b11 && !early && n == 64, {early, irdy}, 3'b011);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Three blocks back to back at full rate.
    do_reset();
    out_ready = 1'b1;
    nout = 0; nlast = 0; gap = 1'b0; dropped = 1'b0; started = 1'b0;
    for (int c = 0; c < 262; c++) begin
      if (c < 192) begin
        in_valid = 1'b1;
        in_data = 8'($urandom);
        if (irdy != 2'b11) dropped = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (oval[0]) begin
        nout++;
        nlast += int'(olast[0]);
        started = 1'b1;
      end else if (started && nout < 192) gap = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_count", nout == 192, nout, 192);
    chk("stream_last", nlast == 3, nlast, 3);
    chk("stream_gapless", !gap && !dropped, {gap, dropped}, 0);
    drain();

    // Reset mid-block discards partial data.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) send(8'(i + 1));
    in_valid = 1'b0;
    #3 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_oval", oval == 2'b00 && irdy == 2'b11, {oval, irdy}, 4'b0011);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) send(8'h10);
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (oval[0]) begin
        if (oidx[0] < 16 || !QT) chk("midrst_data", odata[0] == 8'h10, odata[0], 8'h10);
        n++;
      end
    end
    chk("midrst_count", n == 64, n, 64);
    @(posedge clk); #1;

    // Random valid/ready traffic.
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 256 && cyc < 3000) begin
      in_valid = ($urandom_range(9) < 7);
      in_data = 8'($urandom);
      out_ready = ($urandom_range(9) < 6);
      if (in_valid && irdy[0]) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_accept", acc == 256, acc, 256);
    drain();
    chk("sb_empty", sbq0.size() == 0 && sbq1.size() == 0, sbq0.size() + sbq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
